// File: rtl/digest_target_check_if.sv
// Memory bus shared between the SHA-256 core and the digest checker.
// Single-port synchronous memory: read data appears one cycle after mem_addr is sampled.
interface digest_target_check_if;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output mem_clk, mem_we, mem_addr, mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_clk, mem_we, mem_addr, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/digest_target_check.sv
// Reads an 8-word digest from memory, compares it against a 256-bit target and
// counts its leading zero bits; optionally writes a status word back.
//
// state   | meaning
// IDLE    | waiting for start; published results held
// RD_WAIT | memory samples mem_addr this cycle
// RD_CAP  | digest word on mem_read_data; compare, count zeros, advance
// WRITE   | one-cycle status word write, then publish results
module digest_target_check #(
  parameter int WRITE_STATUS = 1,
  parameter int DIGEST_WORDS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [15:0]          digest_addr,
  input  logic [15:0]          result_addr,
  input  logic [255:0]         target,
  output logic                 done,
  output logic                 meets_target,
  output logic [8:0]           lz_count,
  digest_target_check_if.master mem
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP, WRITE} state_t;

  localparam logic [2:0] LAST_IDX = 3'(DIGEST_WORDS - 1);

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [255:0]  tgt_q, tgt_d;
  logic [15:0]   raddr_q, raddr_d;
  logic          decided_q, decided_d;
  logic          meets_q, meets_d;
  logic          still_zero_q, still_zero_d;
  logic [8:0]    lz_q, lz_d;
  logic          done_q, done_d;
  logic          meets_target_q, meets_target_d;
  logic [8:0]    lz_count_q, lz_count_d;
  logic          mem_we_q, mem_we_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_write_data_q, mem_write_data_d;

  logic [31:0]   rd_word;
  logic [31:0]   tgt_word;

  function automatic logic [5:0] clz32(input logic [31:0] w);
    logic [5:0] n;
    logic       seen;
    n    = 6'd0;
    seen = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!seen) begin
        if (w[i]) seen = 1'b1;
        else      n = n + 6'd1;
      end
    end
    return n;
  endfunction

  assign rd_word  = mem.mem_read_data;
  // H0 sits in the top word of the target, so word idx is at bit offset (7-idx)*32.
  assign tgt_word = tgt_q[{~idx_q, 5'b0} +: 32];

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    tgt_d            = tgt_q;
    raddr_d          = raddr_q;
    decided_d        = decided_q;
    meets_d          = meets_q;
    still_zero_d     = still_zero_q;
    lz_d             = lz_q;
    done_d           = done_q;
    meets_target_d   = meets_target_q;
    lz_count_d       = lz_count_q;
    mem_we_d         = mem_we_q;
    mem_addr_d       = mem_addr_q;
    mem_write_data_d = mem_write_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d        = target;
          raddr_d      = result_addr;
          mem_addr_d   = digest_addr;
          idx_d        = 3'd0;
          decided_d    = 1'b0;
          still_zero_d = 1'b1;
          lz_d         = 9'd0;
          done_d       = 1'b0;
          state_d      = RD_WAIT;
        end
      end
      RD_WAIT: state_d = RD_CAP;
      RD_CAP: begin
        if (!decided_q) begin
          if (rd_word < tgt_word) begin
            meets_d   = 1'b1;
            decided_d = 1'b1;
          end else if (rd_word > tgt_word) begin
            meets_d   = 1'b0;
            decided_d = 1'b1;
          end
        end
        if (still_zero_q) begin
          if (rd_word == 32'd0) begin
            lz_d = lz_q + 9'd32;
          end else begin
            lz_d         = lz_q + {3'b000, clz32(rd_word)};
            still_zero_d = 1'b0;
          end
        end
        if (idx_q != LAST_IDX) begin
          idx_d      = idx_q + 3'd1;
          mem_addr_d = mem_addr_q + 16'd1;
          state_d    = RD_WAIT;
        end else begin
          // Every word equal to the target still counts as meeting it.
          if (!decided_d) meets_d = 1'b1;
          if (WRITE_STATUS != 0) begin
            mem_addr_d       = raddr_q;
            mem_write_data_d = {meets_d, 22'b0, lz_d};
            mem_we_d         = 1'b1;
            state_d          = WRITE;
          end else begin
            meets_target_d = meets_d;
            lz_count_d     = lz_d;
            done_d         = 1'b1;
            state_d        = IDLE;
          end
        end
      end
      WRITE: begin
        mem_we_d       = 1'b0;
        meets_target_d = meets_q;
        lz_count_d     = lz_q;
        done_d         = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      idx_q            <= 3'd0;
      tgt_q            <= '0;
      raddr_q          <= 16'd0;
      decided_q        <= 1'b0;
      meets_q          <= 1'b0;
      still_zero_q     <= 1'b0;
      lz_q             <= 9'd0;
      done_q           <= 1'b0;
      meets_target_q   <= 1'b0;
      lz_count_q       <= 9'd0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= 16'd0;
      mem_write_data_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      tgt_q            <= tgt_d;
      raddr_q          <= raddr_d;
      decided_q        <= decided_d;
      meets_q          <= meets_d;
      still_zero_q     <= still_zero_d;
      lz_q             <= lz_d;
      done_q           <= done_d;
      meets_target_q   <= meets_target_d;
      lz_count_q       <= lz_count_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  assign done               = done_q;
  assign meets_target       = meets_target_q;
  assign lz_count           = lz_count_q;
  assign mem.mem_clk        = clk;
  assign mem.mem_we         = mem_we_q;
  assign mem.mem_addr       = mem_addr_q;
  assign mem.mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_digest_target_check.sv
// Scoreboard bench: two checkers (status write on / off) on private memories,
// expected results queued at start and compared when done rises.
module tb_digest_target_check;

  typedef struct {
    logic        meets;
    logic [8:0]  lz;
    logic [15:0] daddr;
    logic [15:0] raddr;
    int          s;
  } exp_t;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [15:0]  digest_addr;
  logic [15:0]  result_addr;
  logic [255:0] target;
  logic         done1, meets1, done0, meets0;
  logic [8:0]   lz1, lz0;

  logic         ld_en;
  logic [15:0]  ld_addr;
  logic [31:0]  ld_data;
  logic [31:0]  mem_a [0:65535];
  logic [31:0]  mem_b [0:65535];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb_q1[$];
  exp_t sb_q0[$];

  logic        done_prev [2];
  logic [9:0]  hold      [2];
  int          we_cnt    [2];
  int          tr_n      [2];
  logic [15:0] tr        [2][32];

  digest_target_check_if bus1 ();
  digest_target_check_if bus0 ();

  digest_target_check #(.WRITE_STATUS(1), .DIGEST_WORDS(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .digest_addr(digest_addr),
    .result_addr(result_addr), .target(target), .done(done1),
    .meets_target(meets1), .lz_count(lz1), .mem(bus1)
  );

  digest_target_check #(.WRITE_STATUS(0), .DIGEST_WORDS(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .digest_addr(digest_addr),
    .result_addr(result_addr), .target(target), .done(done0),
    .meets_target(meets0), .lz_count(lz0), .mem(bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  always @(posedge clk) begin
    if (ld_en) begin
      mem_a[ld_addr] <= ld_data;
      mem_b[ld_addr] <= ld_data;
    end
    if (bus1.mem_we) mem_a[bus1.mem_addr] <= bus1.mem_write_data;
    if (bus0.mem_we) mem_b[bus0.mem_addr] <= bus0.mem_write_data;
    bus1.mem_read_data <= mem_a[bus1.mem_addr];
    bus0.mem_read_data <= mem_b[bus0.mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_lz(input logic [255:0] d);
    for (int i = 255; i >= 0; i--)
      if (d[i]) return 9'(255 - i);
    return 9'd256;
  endfunction

  task automatic mon(input int k, input logic dn, input logic mt, input logic [8:0] lz,
                     input logic we, input logic [15:0] ad);
    exp_t        e;
    int          sz;
    string       pre;
    logic [15:0] a_exp;
    pre = (k == 1) ? "ws1_" : "ws0_";
    sz  = (k == 1) ? sb_q1.size() : sb_q0.size();
    if (sz != 0) begin
      if (k == 1) e = sb_q1[0];
      else        e = sb_q0[0];
      if (dn && !done_prev[k]) begin
        if (k == 1) void'(sb_q1.pop_front());
        else        void'(sb_q0.pop_front());
        chk({pre, "meets"}, mt, e.meets);
        chk({pre, "lz"}, lz, e.lz);
        chk({pre, "latency"}, cyc - e.s - 1, (k == 1) ? 17 : 16);
        chk({pre, "we_cycles"}, we_cnt[k], (k == 1) ? 1 : 0);
        chk({pre, "rd_samples"}, tr_n[k], 16);
        for (int j = 0; j < tr_n[k] && j < 16; j++) begin
          a_exp = e.daddr + 16'(j / 2);
          chk({pre, "rd_addr"}, tr[k][j], a_exp);
        end
        if (k == 1) chk("ws1_status", mem_a[e.raddr], {e.meets, 22'b0, e.lz});
        hold[k]   = {e.meets, e.lz};
        tr_n[k]   = 0;
        we_cnt[k] = 0;
      end else begin
        chk({pre, "busy_hold"}, {dn, mt, lz}, {1'b0, hold[k]});
        if (we) we_cnt[k]++;
        else if (tr_n[k] < 32) begin
          tr[k][tr_n[k]] = ad;
          tr_n[k]++;
        end
      end
    end
    done_prev[k] = dn;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      done_prev[k] = 1'b0;
      hold[k]      = '0;
      we_cnt[k]    = 0;
      tr_n[k]      = 0;
    end
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sb_q1.delete();
        sb_q0.delete();
        for (int k = 0; k < 2; k++) begin
          done_prev[k] = 1'b0;
          hold[k]      = '0;
          we_cnt[k]    = 0;
          tr_n[k]      = 0;
        end
      end else begin
        mon(1, done1, meets1, lz1, bus1.mem_we, bus1.mem_addr);
        mon(0, done0, meets0, lz0, bus0.mem_we, bus0.mem_addr);
      end
    end
  end

  task automatic load(input logic [255:0] dg, input logic [15:0] da, input logic [15:0] ra);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = da + 16'(i);
      ld_data = dg[255 - 32*i -: 32];
    end
    @(negedge clk);
    ld_addr = ra;
    ld_data = 32'hDEAD_BEEF;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // mode 0: plain run, 1: start pulse + input changes mid-read, 2: reset during WRITE
  task automatic run(input logic [255:0] dg, input logic [255:0] tg,
                     input logic [15:0] da, input logic [15:0] ra, input int mode);
    exp_t e;
    int   n;
    load(dg, da, ra);
    @(negedge clk);
    start       = 1'b1;
    target      = tg;
    digest_addr = da;
    result_addr = ra;
    e.meets = (dg <= tg);
    e.lz    = ref_lz(dg);
    e.daddr = da;
    e.raddr = ra;
    e.s     = cyc;
    #1;
    sb_q1.push_back(e);
    sb_q0.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (mode == 1) begin
      repeat (5) @(negedge clk);
      start       = 1'b1;
      target      = ~tg;
      digest_addr = da + 16'd3;
      result_addr = ra + 16'd1;
      @(negedge clk);
      start = 1'b0;
    end
    if (mode == 2) begin
      n = 0;
      while (!bus1.mem_we && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("we_seen", bus1.mem_we, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_we", bus1.mem_we, 1'b0);
      chk("rst_done", done1, 1'b0);
      chk("rst_meets", meets1, 1'b0);
      chk("rst_lz", lz1, 9'd0);
      @(negedge clk);
      #2 reset_n = 1'b1;
    end
    n = 0;
    while ((sb_q1.size() != 0 || sb_q0.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("timeout", (n < 60), 1'b1);
    sb_q1.delete();
    sb_q0.delete();
    repeat (2) @(negedge clk);
  endtask

  logic [255:0] pat, dg, tg, one;

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    target      = '0;
    digest_addr = 16'd0;
    result_addr = 16'd0;
    ld_en       = 1'b0;
    ld_addr     = 16'd0;
    ld_data     = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_done0", done1, 1'b0);
    chk("rst_mem_addr", bus1.mem_addr, 16'd0);
    chk("rst_mem_we", bus1.mem_we, 1'b0);
    chk("rst_wdata", bus1.mem_write_data, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_results", {done1, meets1, lz1, done0, meets0, lz0}, 22'd0);
    @(posedge clk);
    #1 chk("mem_clk", bus1.mem_clk, clk);

    run('0, {256{1'b1}}, 16'h0100, 16'h0200, 0);
    run({32'h0, 32'h0000FFFF, {6{32'hFFFF_FFFF}}}, {32'h0, 32'h0001_0000, 192'h0},
        16'h0300, 16'h0400, 0);
    pat = {32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
           32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
    run(pat, pat, 16'h1000, 16'h1100, 0);
    run(pat, pat - 256'd1, 16'h1000, 16'h1100, 0);
    run({32'h8000_0000, 224'h0}, {32'h7FFF_FFFF, {7{32'hFFFF_FFFF}}}, 16'h2000, 16'h2100, 0);
    run(pat, pat + 256'd5, 16'h3000, 16'h3100, 1);
    run({32'h0, 32'h0000_0001, pat[191:0]}, pat, 16'hFFFC, 16'h0200, 1);
    run(pat, pat, 16'h4000, 16'h4100, 2);
    run({64'h0, pat[191:0]}, {64'h0, pat[191:0]} - 256'd1, 16'h4000, 16'h4100, 0);

    one = 256'd1;
    for (int r = 0; r < 6; r++) begin
      dg = '0;
      for (int j = 0; j < 8; j++) dg = {dg[223:0], $urandom()};
      if (r == 2) dg[255:200] = '0;
      case ($urandom_range(0, 2))
        0:       tg = dg;
        1:       tg = dg ^ (one << $urandom_range(0, 255));
        default: begin
          tg = '0;
          for (int j = 0; j < 8; j++) tg = {tg[223:0], $urandom()};
        end
      endcase
      run(dg, tg, 16'(16'h5000 + 16'(r * 32)), 16'h6000, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digest_target_check.md
Name: digest_target_check

Overview:
Downstream consumer of the SHA-256 core. After the core writes its 8-word digest (H0..H7) to shared memory, this block reads the digest back and compares it, as a 256-bit unsigned number, against a difficulty target. It reports pass/fail and the leading-zero bit count, and optionally writes a status word to memory. It shares the core's single-port synchronous memory bus, so the two never drive the bus at the same time.

Parameters:
WRITE_STATUS, 1, 1 = write status word to result_addr after compare; 0 = skip the write phase.
DIGEST_WORDS, 8, words in digest; fixed at 8, present only for readability.

Ports:
clk  input  1  system clock; also forwarded as mem_clk.
reset_n  input  1  asynchronous active-low reset.
start  input  1  begin a check; sampled only in IDLE.
digest_addr  input  16  memory address of H0; H1..H7 follow consecutively.
result_addr  input  16  address for the status word.
target  input  256  difficulty target, H0-aligned ([255:224] compares against H0); captured at start.
done  output  1  level; set on completion, cleared by the next accepted start.
meets_target  output  1  1 when digest <= target, unsigned; valid while done=1.
lz_count  output  9  leading zero bits of digest, 0..256; valid while done=1.
mem_clk  output  1  equals clk.
mem_we  output  1  memory write enable.
mem_addr  output  16  memory address, driven from a register.
mem_write_data  output  32  status word.
mem_read_data  input  32  synchronous read data; 1-cycle latency after the address is sampled.

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values: state=IDLE; done=0, meets_target=0, lz_count=0, mem_we=0, mem_addr=0, mem_write_data=0; internal index, flags and target register all 0.
- States: IDLE, RD_WAIT, RD_CAP, WRITE.
- IDLE with start=1:
  - tgt<=target; mem_addr<=digest_addr; idx<=0.
  - decided<=0; still_zero<=1; lz<=0; done<=0.
  - Next state RD_WAIT.
- IDLE with start=0: hold all outputs, including done and results.
- RD_WAIT: one cycle so the memory samples mem_addr. Next state RD_CAP.
- RD_CAP: capture w=mem_read_data and update in the same edge:
  - Compare, if decided=0: w < tgt word idx -> meets<=1, decided<=1. w > tgt word idx -> meets<=0, decided<=1. Equal -> no change.
  - Leading zeros, if still_zero=1: w==0 -> lz+=32. Otherwise lz+=clz(w) and still_zero<=0.
  - idx<7: idx++, mem_addr++, next state RD_WAIT.
  - idx==7 and decided=0 (all words equal): meets<=1.
  - idx==7 and WRITE_STATUS=1: next state WRITE, with mem_addr<=result_addr, mem_write_data<={meets_final, 22'b0, lz_final}, mem_we<=1.
  - idx==7 and WRITE_STATUS=0: publish results, done<=1, next state IDLE.
- WRITE: exactly one cycle with mem_we=1. On exit mem_we<=0, publish meets_target and lz_count, done<=1, next state IDLE.
- Read order is fixed at 8 reads. There is no early exit, so lz_count is exact.
- Latency, start sampled at edge E0:
  - Word i is captured at edge E(2i+2); H7 at E16.
  - WRITE_STATUS=1: done rises after E17. WRITE_STATUS=0: done rises after E16.
- Output stability: meets_target and lz_count change only when done is set. They stay 0 from reset until the first completion.
- Inputs that do not matter:
  - start while busy (not IDLE) is ignored and not queued.
  - Changes to target, digest_addr or result_addr after the start edge have no effect.
- Width rules:
  - lz is 9 bits; the maximum of 256 is reached only for an all-zero digest.
  - mem_addr increments wrap modulo 2^16 (digest_addr=16'hFFFC reads FFFC..0003).
- Reset mid-operation: the block returns to IDLE immediately and mem_we drops asynchronously. A partially written status word is not retried.
- mem_we is 1 only in WRITE.

Test Plan:
- Digest all zeros, target all ones -> meets_target=1, lz_count=256, status word 32'h80000100 at result_addr, done 17 cycles after start.
- Digest H0=32'h00000000, H1=32'h0000FFFF, rest FF..; target H0=0, H1=32'h00010000 -> meets_target=1 (decided at H1), lz_count=48.
- Digest equal to target (H0..H7 = 32'h6A09E667.. pattern) -> meets_target=1; then the same digest with target H7-1 -> meets_target=0.
- Digest H0=32'h80000000, target H0=32'h7FFFFFFF -> meets_target=0, lz_count=0; WRITE_STATUS=0 -> no mem_we pulse, done 16 cycles after start.
- Pulse start mid-read and change target mid-read -> result unaffected, exactly 8 read addresses issued; digest_addr=16'hFFFC -> addresses wrap to 16'h0000..0003.
- Assert reset_n low in WRITE -> mem_we drops immediately, done=0, results 0; the next start completes normally with correct values.
